// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - registered ALU operand-prep stage with 2-entry skid buffer
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_a_sel,
  input  logic            in_b_sel,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic            out_is_shift,
  output logic            out_sel_sr,
  output logic            out_sra,
  output logic [4:0]      out_rd
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            is_shift;
    logic            sel_sr;
    logic            sra;
    logic [4:0]      rd;
  } bundle_t;

  bundle_t prep;
  bundle_t main_q;
  bundle_t skid_q;
  logic    main_valid;
  logic    skid_valid;
  logic    in_fire;
  logic    out_fire;
  logic [XLEN-1:0] b_raw;

  // The shifter zeroes results for B > 31, so shift amounts are masked here.
  always_comb begin
    prep          = '0;
    b_raw         = in_b_sel ? in_imm : in_rs2_data;
    prep.a        = in_a_sel ? in_pc : in_rs1_data;
    prep.is_shift = (in_funct3[1:0] == 2'b01);
    prep.sel_sr   = (in_funct3 == 3'b101);
    prep.sra      = (in_funct3 == 3'b101) && in_funct7_5;
    prep.b        = prep.is_shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
    prep.rd       = in_rd;
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      // Skid holds the older bundle; while it is valid in_ready is low.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q     <= prep;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= prep;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready     = !skid_valid;
  assign out_valid    = main_valid;
  assign out_a        = main_q.a;
  assign out_b        = main_q.b;
  assign out_is_shift = main_q.is_shift;
  assign out_sel_sr   = main_q.sel_sr;
  assign out_sra      = main_q.sra;
  assign out_rd       = main_q.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - randomized self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic        in_a_sel, in_b_sel, in_funct7_5;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic        out_is_shift, out_sel_sr, out_sra;
  logic [4:0]  out_rd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sh;
    logic        sr;
    logic        sra;
    logic [4:0]  rd;
  } exp_t;

  exp_t        q[$];
  logic [4:0]  obs_rd[$];
  bit          last_in_fire;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_is_shift(out_is_shift),
    .out_sel_sr(out_sel_sr), .out_sra(out_sra), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_bundle();
    exp_t e;
    logic [31:0] bsrc;
    bit shift;
    shift = (in_funct3 == 3'd1) || (in_funct3 == 3'd5);
    bsrc  = in_b_sel ? in_imm : in_rs2_data;
    e.a   = in_a_sel ? in_pc : in_rs1_data;
    e.b   = shift ? (bsrc % 32) : bsrc;
    e.sh  = shift;
    e.sr  = (in_funct3 == 3'd5);
    e.sra = (in_funct3 == 3'd5) && in_funct7_5;
    e.rd  = in_rd;
    return e;
  endfunction

  // Advance one clock: update the model from the inputs now applied, then compare.
  task automatic step();
    bit ofire, ifire;
    exp_t e;
    last_in_fire = 0;
    if (rst || flush) begin
      q.delete();
    end else begin
      ofire = (q.size() > 0) && out_ready;
      ifire = in_valid && (q.size() < 2);
      if (out_valid && out_ready) obs_rd.push_back(out_rd);
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        e = ref_bundle();
        q.push_back(e);
      end
      last_in_fire = ifire;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() < 2);
    if (q.size() != 0) begin
      check("out_a", out_a, q[0].a);
      check("out_b", out_b, q[0].b);
      check("out_is_shift", out_is_shift, q[0].sh);
      check("out_sel_sr", out_sel_sr, q[0].sr);
      check("out_sra", out_sra, q[0].sra);
      check("out_rd", out_rd, q[0].rd);
    end
  endtask

  task automatic randomize_payload();
    in_rs1_data = $urandom;
    in_rs2_data = $urandom;
    in_pc       = $urandom;
    in_imm      = $urandom;
    in_a_sel    = $urandom_range(0, 1);
    in_b_sel    = $urandom_range(0, 1);
    in_funct3   = 3'($urandom_range(0, 7));
    in_funct7_5 = $urandom_range(0, 1);
    in_rd       = 5'($urandom_range(0, 31));
  endtask

  initial begin
    bit saw_stall;
    int cyc;
    int sent;

    rst = 1; flush = 0; in_valid = 1; out_ready = 1;
    randomize_payload();
    last_in_fire = 0;

    // Reset held two cycles with in_valid asserted.
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    q.delete();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_flags", {out_is_shift, out_sel_sr, out_sra}, 0);
    check("rst_out_rd", out_rd, 0);
    rst = 0; in_valid = 0;
    step();

    // Operand select with immediate shift amount masking.
    in_valid = 1; in_rs1_data = 32'h8000_0001; in_imm = 32'h0000_0FE5;
    in_a_sel = 0; in_b_sel = 1; in_funct3 = 3'b001; in_funct7_5 = 0; in_rd = 5'd3;
    step();
    check("sel_a", out_a, 32'h8000_0001);
    check("sel_b_mask", out_b, 32'h0000_0005);
    check("sel_is_shift", out_is_shift, 1);
    check("sel_sel_sr", out_sel_sr, 0);

    // Register SRA decode.
    in_rs2_data = 32'hFFFF_FF3F; in_b_sel = 0; in_funct3 = 3'b101; in_funct7_5 = 1;
    step();
    check("sra_b", out_b, 32'h0000_001F);
    check("sra_sel_sr", out_sel_sr, 1);
    check("sra_sra", out_sra, 1);

    // Non-shift B passes unmasked.
    in_funct3 = 3'b000; in_pc = 32'h0000_1000; in_a_sel = 1; in_b_sel = 1;
    in_imm = 32'hFFFF_FFFC; in_funct7_5 = 0;
    step();
    check("ns_a", out_a, 32'h0000_1000);
    check("ns_b", out_b, 32'hFFFF_FFFC);
    check("ns_is_shift", out_is_shift, 0);

    in_valid = 0;
    step();
    step();

    // Backpressure: stream rd=1..6, out_ready low for 3 cycles.
    obs_rd.delete();
    sent = 1; cyc = 0; saw_stall = 0;
    while ((sent <= 6 || q.size() != 0) && cyc < 40) begin
      if (sent <= 6) begin
        randomize_payload();
        in_rd = 5'(sent);
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      out_ready = (cyc >= 1 && cyc <= 3) ? 0 : 1;
      step();
      if (last_in_fire) sent++;
      if (!in_ready) saw_stall = 1;
      cyc++;
    end
    check("bp_done", (cyc < 40), 1);
    check("bp_stall_seen", saw_stall, 1);
    check("bp_count", obs_rd.size(), 6);
    for (int i = 0; i < obs_rd.size() && i < 6; i++)
      check("bp_order", obs_rd[i], i + 1);

    // Flush with both entries full and a bundle on the input.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      randomize_payload();
      in_rd = 5'(20 + i);
      step();
    end
    check("fl_full", in_ready, 0);
    flush = 1; out_ready = 1; in_rd = 5'd30;
    step();
    flush = 0; in_valid = 0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      randomize_payload();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 4);
      step();
    end
    flush = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Registered operand-preparation stage between register-read/decode and the ALU execute stage. It selects the ALU A/B operands, decodes shift operations, masks the shift amount to 5 bits, and presents one registered bundle to the ALU and shifter. The shifter treats any B value above 31 as a zero result, so this masking is required. Ready/valid handshakes on both sides; a 2-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (branch mispredict/trap); synchronous
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept; registered
- in_rs1_data  in  32  register rs1 value
- in_rs2_data  in  32  register rs2 value
- in_pc  in  32  instruction PC
- in_imm  in  32  sign-extended immediate
- in_a_sel  in  1  0: A=rs1, 1: A=pc
- in_b_sel  in  1  0: B=rs2, 1: B=imm
- in_funct3  in  3  RISC-V funct3
- in_funct7_5  in  1  funct7 bit 5 (SUB/SRA)
- in_rd  in  5  destination register
- out_valid  out  1  bundle valid to ALU
- out_ready  in  1  ALU accepts
- out_a  out  32  operand A
- out_b  out  32  operand B; for shifts {27'b0, B[4:0]}
- out_is_shift  out  1  funct3 is 001 or 101
- out_sel_sr  out  1  1 for funct3=101 (right shift), else 0
- out_sra  out  1  funct3=101 and funct7_5=1
- out_rd  out  5  destination register

## Operation
- Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Combinational prep before capture: A/B mux, shift decode, and shift-amount mask. The mask applies for both immediate (`in_b_sel=1`) and register shifts. Non-shift B passes unmasked.
- Storage: main register (drives outputs) and skid register, each with a valid bit.
- Main empty, or main transferring this cycle: the incoming bundle (or the skid contents, if the skid is valid) loads main. Skid contents have priority, so order is preserved.
- Main full and not transferring, with an input transfer: the bundle goes to the skid.
- in_ready = !skid_valid, registered. Skid valid deasserts only after its contents move to main.
- Payload registers hold their value when not loaded; they are don't-care while their valid bit is 0.
- flush: both valid bits clear next cycle. An input bundle presented in the flush cycle is discarded, and so is any output transfer in that cycle (downstream also flushes). in_ready is 1 the cycle after flush.
- rst has priority over flush. Reset values: out_valid=0, skid_valid=0, in_ready=1, out_a=0, out_b=0, out_is_shift=0, out_sel_sr=0, out_sra=0, out_rd=0.

## Timing
- Latency: bundle accepted in cycle N appears on outputs in cycle N+1.
- Throughput: 1 bundle/cycle while out_ready=1.
- out_ready low with main full:
  - the next accepted bundle fills the skid;
  - in_ready drops the following cycle;
  - at most 2 bundles are held.
- out_ready rising with both full: the skid moves to main the same edge as the main transfer, and in_ready returns 1 the next cycle.
- Outputs are stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready.

## Test plan
- Reset:
  - stimulus: hold rst 2 cycles with in_valid=1;
  - required: out_valid=0, in_ready=1, all outputs 0.
- Operand select and mask:
  - stimulus: rs1=0x8000_0001, imm=0x0000_0FE5, a_sel=0, b_sel=1, funct3=001;
  - required: next cycle out_a=0x8000_0001, out_b=0x0000_0005, out_is_shift=1, out_sel_sr=0.
- SRA decode:
  - stimulus: rs2=0xFFFF_FF3F, b_sel=0, funct3=101, funct7_5=1;
  - required: out_b=0x1F, out_sel_sr=1, out_sra=1.
- Non-shift pass-through:
  - stimulus: funct3=000, pc=0x0000_1000, a_sel=1, imm=0xFFFF_FFFC;
  - required: out_a=0x1000, out_b=0xFFFF_FFFC unmasked, out_is_shift=0.
- Backpressure:
  - stimulus: stream rd=1..6 each cycle; out_ready=0 for 3 cycles, then 1;
  - required: in_ready low after skid fills, no loss or duplication, out_rd order 1..6.
- Flush:
  - stimulus: both entries full, assert flush with in_valid=1;
  - required: next cycle out_valid=0, in_ready=1, flushed bundles never appear.
